cache_mem_arbiter: RTL and testbench

- Arbitrates the single physical-memory port between the instruction cache (I) and the data cache (D) of the pipelined LC-3b core.
- Latches the winning request and drives it to physical memory until pmem_resp arrives.
- Routes the response and read line back to the winning cache only.
- Sits between the L1 caches and the pmem/L2 interface; each transfer is one full cache line.

---
 rtl/cache_mem_arbiter.sv | 101 ++++++++++
 tb/tb_cache_mem_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one line-wide memory port between I-cache and D-cache.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise D has fixed priority over I.
module cache_mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);
   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic                write_q, write_d;
   logic                pmem_read_q, pmem_read_d;
   logic                pmem_write_q, pmem_write_d;
   logic                d_req, grant_d;
`ifdef ARB_ROUND_ROBIN_EN
   logic                prio_i_q, prio_i_d;
`endif
   always_comb begin
      d_req = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
      grant_d = d_req & (~i_read | ~prio_i_q);
`else
      grant_d = d_req;
`endif
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      if (state_q == IDLE) begin
         if (grant_d) begin
            state_d = SERVE_D;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            write_d = d_write;
         end else if (i_read) begin
            state_d = SERVE_I;
            addr_d  = i_addr;
            write_d = 1'b0;
         end
      end else if (pmem_resp) begin
         state_d = IDLE;
      end
      pmem_read_d  = (state_d != IDLE) & ~write_d;
      pmem_write_d = (state_d != IDLE) & write_d;
`ifdef ARB_ROUND_ROBIN_EN
      // favour whichever side did not win the latest grant
      prio_i_d = (state_q == IDLE && state_d == SERVE_D) ? 1'b1 :
                 (state_q == IDLE && state_d == SERVE_I) ? 1'b0 : prio_i_q;
`endif
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         prio_i_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         write_q      <= write_d;
         pmem_read_q  <= pmem_read_d;
         pmem_write_q <= pmem_write_d;
`ifdef ARB_ROUND_ROBIN_EN
         prio_i_q     <= prio_i_d;
`endif
      end
   end
   assign pmem_read  = pmem_read_q;
   assign pmem_write = pmem_write_q;
   assign pmem_addr  = addr_q;
   assign pmem_wdata = wdata_q;
   assign i_resp     = (state_q == SERVE_I) & pmem_resp;
   assign d_resp     = (state_q == SERVE_D) & pmem_resp;
   assign i_rdata    = i_resp ? pmem_rdata : '0;
   assign d_rdata    = d_resp ? pmem_rdata : '0;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed checks of the default (fixed D > I priority) arbiter build.
module tb_cache_mem_arbiter;
   logic         clk = 1'b0;
   logic         reset;
   logic         i_read, i_resp, d_read, d_write, d_resp;
   logic         pmem_read, pmem_write, pmem_resp;
   logic [15:0]  i_addr, d_addr, pmem_addr;
   logic [127:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
   int           n_chk = 0;
   int           n_fail = 0;
   localparam logic [127:0] A5 = {16{8'hA5}};
   localparam logic [127:0] WB = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] RD = 128'hDEADBEEF_00000000_CAFEF00D_12345678;

   cache_mem_arbiter dut (
      .clk(clk), .reset(reset),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
      tick(); tick();
      check("rst_rd", pmem_read, 0);
      check("rst_wr", pmem_write, 0);
      check("rst_addr", pmem_addr, 0);
      check("rst_wdata", pmem_wdata, 0);
      check("rst_iresp", i_resp, 0);
      check("rst_drdata", d_rdata, 0);
      reset = 1'b0;
      // single I read
      i_read = 1; i_addr = 16'h0040;
      tick();
      check("i_rd", pmem_read, 1);
      check("i_wr", pmem_write, 0);
      check("i_addr", pmem_addr, 16'h0040);
      tick(); tick();
      check("i_hold", pmem_read, 1);
      check("i_nopulse", i_resp, 0);
      pmem_resp = 1; pmem_rdata = A5; #1;
      check("i_resp", i_resp, 1);
      check("i_rdata", i_rdata, A5);
      check("i_dresp", d_resp, 0);
      tick();
      i_read = 0; pmem_resp = 0; #1;
      check("i_done_rd", pmem_read, 0);
      check("i_done_resp", i_resp, 0);
      check("i_done_rdata", i_rdata, 0);
      // stray response in IDLE
      pmem_resp = 1; #1;
      check("stray_iresp", i_resp, 0);
      check("stray_dresp", d_resp, 0);
      tick();
      check("stray_rd", pmem_read, 0);
      check("stray_wr", pmem_write, 0);
      pmem_resp = 0;
      // D writeback
      d_write = 1; d_addr = 16'h1230; d_wdata = WB;
      tick();
      check("wb_wr", pmem_write, 1);
      check("wb_rd", pmem_read, 0);
      check("wb_addr", pmem_addr, 16'h1230);
      check("wb_wdata", pmem_wdata, WB);
      tick();
      pmem_resp = 1; #1;
      check("wb_dresp", d_resp, 1);
      check("wb_iresp", i_resp, 0);
      tick();
      d_write = 0; pmem_resp = 0; #1;
      check("wb_done", pmem_write, 0);
      // simultaneous requests: D wins, inputs frozen, then I after one IDLE cycle
      i_read = 1; i_addr = 16'h0010; d_read = 1; d_addr = 16'h2000;
      tick();
      check("tie_addr", pmem_addr, 16'h2000);
      check("tie_rd", pmem_read, 1);
      d_addr = 16'hFFFF;
      tick();
      check("frz_addr", pmem_addr, 16'h2000);
      check("frz_iresp", i_resp, 0);
      pmem_resp = 1; pmem_rdata = RD; #1;
      check("tie_dresp", d_resp, 1);
      check("tie_drdata", d_rdata, RD);
      check("tie_iresp", i_resp, 0);
      check("tie_irdata", i_rdata, 0);
      tick();
      d_read = 0; pmem_resp = 0; #1;
      check("turn_rd", pmem_read, 0);
      tick();
      check("tie2_addr", pmem_addr, 16'h0010);
      check("tie2_rd", pmem_read, 1);
      // reset while serving I
      reset = 1;
      tick();
      reset = 0; i_read = 0;
      check("mr_rd", pmem_read, 0);
      check("mr_wr", pmem_write, 0);
      pmem_resp = 1; #1;
      check("mr_iresp", i_resp, 0);
      check("mr_dresp", d_resp, 0);
      tick();
      pmem_resp = 0;
      check("mr_idle", pmem_read, 0);
      // read and write together count as a write
      d_read = 1; d_write = 1; d_addr = 16'h3330; d_wdata = RD;
      tick();
      check("rw_wr", pmem_write, 1);
      check("rw_rd", pmem_read, 0);
      check("rw_wdata", pmem_wdata, RD);
      pmem_resp = 1; #1;
      check("rw_dresp", d_resp, 1);
      tick();
      d_read = 0; d_write = 0; pmem_resp = 0; #1;
      check("rw_done", pmem_write, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
